// File: rtl/execute_md.sv
// Execute stage of the pipelined RISC-V core: forwarding, ALU and a multi-cycle
// multiply/divide unit that stalls the upstream stages while it runs.
module execute_md #(
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  PIP_operand1_i,
    input  logic [XLEN-1:0]  PIP_operand2_i,
    input  logic [XLEN-1:0]  PIP_immediate_i,
    input  logic [REG_W-1:0] PIP_rd_i,
    input  logic [3:0]       PIP_aluOper_i,
    input  logic             PIP_use_imm_i,
    input  logic             PIP_md_valid_i,
    input  logic [2:0]       PIP_md_op_i,
    input  logic             PIP_write_mem_i,
    input  logic             PIP_read_mem_i,
    input  logic             PIP_use_mem_i,
    input  logic             PIP_write_reg_i,
    input  logic             use_EX_MEM_rs1_i,
    input  logic             use_EX_MEM_rs2_i,
    input  logic             use_MEM_WB_rs1_i,
    input  logic             use_MEM_WB_rs2_i,
    input  logic [XLEN-1:0]  EX_MEM_operand_i,
    input  logic [XLEN-1:0]  MEM_WB_operand_i,
    output logic [XLEN-1:0]  PIP_alu_result_o,
    output logic [XLEN-1:0]  PIP_second_operand_o,
    output logic [REG_W-1:0] PIP_rd_o,
    output logic             PIP_write_mem_o,
    output logic             PIP_read_mem_o,
    output logic             PIP_use_mem_o,
    output logic             PIP_write_reg_o,
    output logic             stall_o,
    output logic             md_busy_o
);

    localparam int SHW  = $clog2(XLEN);
    localparam int NMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW   = $clog2(NMAX);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   rs1, rs2, opb, alu_result;
    logic [SHW-1:0]    shamt;
    logic              accept, complete, bubble;
    logic [CW-1:0]     count;
    logic [2:0]        md_op;
    logic [XLEN-1:0]   md_a, md_b;
    logic [XLEN-1:0]   quot, rem, divisor;
    logic              neg_q, neg_r, div_zero;
    logic              signed_div, a_neg, b_neg;
    logic [XLEN:0]     shifted, diff;
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   q_res, r_res, md_result;

    // Operand selection: the youngest producer wins.
    always_comb begin
        rs1 = use_EX_MEM_rs1_i ? EX_MEM_operand_i :
              use_MEM_WB_rs1_i ? MEM_WB_operand_i : PIP_operand1_i;
        rs2 = use_EX_MEM_rs2_i ? EX_MEM_operand_i :
              use_MEM_WB_rs2_i ? MEM_WB_operand_i : PIP_operand2_i;
        opb = PIP_use_imm_i ? PIP_immediate_i : rs2;
        shamt = opb[SHW-1:0];
    end

    always_comb begin
        alu_result = '0;
        case (PIP_aluOper_i)
            ALU_ADD:  alu_result = rs1 + opb;
            ALU_SUB:  alu_result = rs1 - opb;
            ALU_AND:  alu_result = rs1 & opb;
            ALU_XOR:  alu_result = rs1 ^ opb;
            ALU_OR:   alu_result = rs1 | opb;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(opb)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, rs1 < opb};
            ALU_SLL:  alu_result = rs1 << shamt;
            ALU_SRA:  alu_result = $signed(rs1) >>> shamt;
            ALU_SRL:  alu_result = rs1 >> shamt;
            default:  alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (PIP_md_valid_i) state_next = BUSY;
                BUSY:    if (count == '0)    state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Stall is gated by reset so upstream is released while reset is held.
    always_comb begin
        accept    = !flush_i && (state == IDLE) && PIP_md_valid_i;
        complete  = !flush_i && (state == DONE);
        stall_o   = !reset && !flush_i &&
                    ((state == BUSY) || ((state == IDLE) && PIP_md_valid_i));
        md_busy_o = (state != IDLE);
        bubble    = flush_i || stall_o;
    end

    // Divide works on magnitudes; signs are reapplied when the result is read.
    always_comb begin
        signed_div = (PIP_md_op_i == MD_DIV) || (PIP_md_op_i == MD_REM);
        a_neg      = signed_div && rs1[XLEN-1];
        b_neg      = signed_div && opb[XLEN-1];
        shifted    = {rem, quot[XLEN-1]};
        diff       = shifted - {1'b0, divisor};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            md_op    <= '0;
            md_a     <= '0;
            md_b     <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (flush_i) begin
            count <= '0;
        end else if (accept) begin
            count    <= PIP_md_op_i[2] ? CW'(XLEN-1) : CW'(MUL_LAT-1);
            md_op    <= PIP_md_op_i;
            md_a     <= rs1;
            md_b     <= opb;
            quot     <= a_neg ? -rs1 : rs1;
            rem      <= '0;
            divisor  <= b_neg ? -opb : opb;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (opb == '0);
        end else if (state == BUSY) begin
            count <= count - CW'(1);
            if (md_op[2]) begin
                if (!diff[XLEN]) begin
                    rem  <= diff[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b1};
                end else begin
                    rem  <= shifted[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Sign-extending to 2*XLEN makes one unsigned multiply serve all four variants.
    always_comb begin
        a_sgn = ((md_op == MD_MULH) || (md_op == MD_MULHSU)) && md_a[XLEN-1];
        b_sgn = (md_op == MD_MULH) && md_b[XLEN-1];
        a_ext = {{XLEN{a_sgn}}, md_a};
        b_ext = {{XLEN{b_sgn}}, md_b};
        prod  = a_ext * b_ext;
        q_res = div_zero ? '1   : (neg_q ? -quot : quot);
        r_res = div_zero ? md_a : (neg_r ? -rem : rem);
        md_result = '0;
        case (md_op)
            MD_MUL:                        md_result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  md_result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               md_result = q_res;
            MD_REM, MD_REMU:               md_result = r_res;
            default:                       md_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble) begin
            PIP_alu_result_o     <= '0;
            PIP_second_operand_o <= '0;
            PIP_rd_o             <= '0;
            PIP_write_mem_o      <= 1'b0;
            PIP_read_mem_o       <= 1'b0;
            PIP_use_mem_o        <= 1'b0;
            PIP_write_reg_o      <= 1'b0;
        end else begin
            PIP_alu_result_o     <= complete ? md_result : alu_result;
            PIP_second_operand_o <= rs2;
            PIP_rd_o             <= PIP_rd_i;
            PIP_write_mem_o      <= PIP_write_mem_i;
            PIP_read_mem_o       <= PIP_read_mem_i;
            PIP_use_mem_o        <= PIP_use_mem_i;
            PIP_write_reg_o      <= PIP_write_reg_i;
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Self-checking bench for execute_md: random ALU and mul/div traffic against an
// arithmetic reference model, plus forwarding, flush and reset scenarios.
module tb_execute_md;

    localparam int XLEN      = 32;
    localparam int REG_W     = 5;
    localparam int MUL_LAT   = 2;
    localparam int MUL_STALL = MUL_LAT + 1;
    localparam int DIV_STALL = XLEN + 1;

    logic             clk, reset, flush_i;
    logic [XLEN-1:0]  PIP_operand1_i, PIP_operand2_i, PIP_immediate_i;
    logic [REG_W-1:0] PIP_rd_i;
    logic [3:0]       PIP_aluOper_i;
    logic             PIP_use_imm_i, PIP_md_valid_i;
    logic [2:0]       PIP_md_op_i;
    logic             PIP_write_mem_i, PIP_read_mem_i, PIP_use_mem_i, PIP_write_reg_i;
    logic             use_EX_MEM_rs1_i, use_EX_MEM_rs2_i, use_MEM_WB_rs1_i, use_MEM_WB_rs2_i;
    logic [XLEN-1:0]  EX_MEM_operand_i, MEM_WB_operand_i;
    logic [XLEN-1:0]  PIP_alu_result_o, PIP_second_operand_o;
    logic [REG_W-1:0] PIP_rd_o;
    logic             PIP_write_mem_o, PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o;
    logic             stall_o, md_busy_o;

    int checks   = 0;
    int failures = 0;

    execute_md #(.XLEN(XLEN), .REG_W(REG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush_i              (flush_i),
        .PIP_operand1_i       (PIP_operand1_i),
        .PIP_operand2_i       (PIP_operand2_i),
        .PIP_immediate_i      (PIP_immediate_i),
        .PIP_rd_i             (PIP_rd_i),
        .PIP_aluOper_i        (PIP_aluOper_i),
        .PIP_use_imm_i        (PIP_use_imm_i),
        .PIP_md_valid_i       (PIP_md_valid_i),
        .PIP_md_op_i          (PIP_md_op_i),
        .PIP_write_mem_i      (PIP_write_mem_i),
        .PIP_read_mem_i       (PIP_read_mem_i),
        .PIP_use_mem_i        (PIP_use_mem_i),
        .PIP_write_reg_i      (PIP_write_reg_i),
        .use_EX_MEM_rs1_i     (use_EX_MEM_rs1_i),
        .use_EX_MEM_rs2_i     (use_EX_MEM_rs2_i),
        .use_MEM_WB_rs1_i     (use_MEM_WB_rs1_i),
        .use_MEM_WB_rs2_i     (use_MEM_WB_rs2_i),
        .EX_MEM_operand_i     (EX_MEM_operand_i),
        .MEM_WB_operand_i     (MEM_WB_operand_i),
        .PIP_alu_result_o     (PIP_alu_result_o),
        .PIP_second_operand_o (PIP_second_operand_o),
        .PIP_rd_o             (PIP_rd_o),
        .PIP_write_mem_o      (PIP_write_mem_o),
        .PIP_read_mem_o       (PIP_read_mem_o),
        .PIP_use_mem_o        (PIP_use_mem_o),
        .PIP_write_reg_o      (PIP_write_reg_o),
        .stall_o              (stall_o),
        .md_busy_o            (md_busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the instruction semantics.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: r = a | b;
            4'd5: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << sh;
            4'd8: r = int'(a) >>> sh;
            4'd9: r = a >> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                             input logic [3:0] ctrl);
        PIP_md_valid_i   = 1'b0;
        PIP_md_op_i      = 3'd0;
        PIP_aluOper_i    = op;
        PIP_operand1_i   = a;
        PIP_operand2_i   = b;
        PIP_immediate_i  = imm;
        PIP_use_imm_i    = use_imm;
        PIP_rd_i         = rd;
        {PIP_write_mem_i, PIP_read_mem_i, PIP_use_mem_i, PIP_write_reg_i} = ctrl;
        use_EX_MEM_rs1_i = 1'b0;
        use_EX_MEM_rs2_i = 1'b0;
        use_MEM_WB_rs1_i = 1'b0;
        use_MEM_WB_rs2_i = 1'b0;
    endtask

    // Issues one M-extension op and reports what the stage did with it.
    task automatic exec_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input bit fwd, output int stalls,
                           output logic [31:0] res, output logic [4:0] rd_out,
                           output logic wr_out, output logic bubble_bad);
        drive_alu(4'($urandom_range(0, 15)), a, b, $urandom, 1'b0, rd, 4'b0001);
        PIP_md_valid_i = 1'b1;
        PIP_md_op_i    = op;
        if (fwd) begin
            PIP_operand1_i   = $urandom;
            use_EX_MEM_rs1_i = 1'b1;
            EX_MEM_operand_i = a;
        end
        #1;
        stalls     = 0;
        bubble_bad = 1'b0;
        while (stall_o === 1'b1 && stalls < 200) begin
            stalls++;
            if (stalls > 1 && (PIP_write_reg_o !== 1'b0 || PIP_rd_o !== 5'd0)) bubble_bad = 1'b1;
            tick();
            if (fwd) EX_MEM_operand_i = $urandom;
        end
        tick();
        res    = PIP_alu_result_o;
        rd_out = PIP_rd_o;
        wr_out = PIP_write_reg_o;
        drive_alu(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        $display("md op=%0d a=%h b=%h -> res=%h stalls=%0d", op, a, b, res, stalls);
    endtask

    task automatic test_reset;
        drive_alu(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd3, 4'b1111);
        PIP_md_valid_i = 1'b1;
        #2;
        checks++;
        if ({PIP_alu_result_o, PIP_second_operand_o, PIP_rd_o} !== '0) begin
            failures++; $display("FAIL reset_data: got %h/%h/%h expected 0", PIP_alu_result_o, PIP_second_operand_o, PIP_rd_o);
        end
        checks++;
        if ({PIP_write_mem_o, PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0000", {PIP_write_mem_o, PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o});
        end
        checks++;
        if ({stall_o, md_busy_o} !== 2'b00) begin
            failures++; $display("FAIL reset_stall_busy: got %b expected 00", {stall_o, md_busy_o});
        end
        tick();
        drive_alu(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_forwarding;
        logic [31:0] v1, v2, ex, mw, f1, f2;
        logic [3:0]  sel;
        drive_alu(4'd0, 32'd100, 32'd0, 32'd3, 1'b1, 5'd7, 4'b0001);
        use_EX_MEM_rs1_i = 1'b1; use_MEM_WB_rs1_i = 1'b1;
        EX_MEM_operand_i = 32'd5; MEM_WB_operand_i = 32'd9;
        tick();
        checks++;
        if (PIP_alu_result_o !== 32'd8) begin
            failures++; $display("FAIL fwd_both: got %0d expected 8", PIP_alu_result_o);
        end
        use_EX_MEM_rs1_i = 1'b0;
        tick();
        checks++;
        if (PIP_alu_result_o !== 32'd12) begin
            failures++; $display("FAIL fwd_memwb: got %0d expected 12", PIP_alu_result_o);
        end
        for (int i = 0; i < 12; i++) begin
            v1 = $urandom; v2 = $urandom; ex = $urandom; mw = $urandom; sel = 4'($urandom);
            drive_alu(4'd0, v1, v2, $urandom, 1'b0, 5'(i + 1), 4'b0001);
            {use_EX_MEM_rs1_i, use_MEM_WB_rs1_i, use_EX_MEM_rs2_i, use_MEM_WB_rs2_i} = sel;
            EX_MEM_operand_i = ex; MEM_WB_operand_i = mw;
            f1 = sel[3] ? ex : (sel[2] ? mw : v1);
            f2 = sel[1] ? ex : (sel[0] ? mw : v2);
            tick();
            $display("fwd sel=%b res=%h store=%h", sel, PIP_alu_result_o, PIP_second_operand_o);
            checks++;
            if (PIP_alu_result_o !== f1 + f2 || PIP_second_operand_o !== f2) begin
                failures++; $display("FAIL fwd_random sel=%b: got %h/%h expected %h/%h", sel, PIP_alu_result_o, PIP_second_operand_o, f1 + f2, f2);
            end
        end
    endtask

    task automatic test_alu_random;
        logic [3:0]  op, ctrl;
        logic [31:0] a, b, imm, exp;
        logic        ui;
        logic [4:0]  rd;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; imm = $urandom;
            ui = 1'($urandom); ctrl = 4'($urandom); rd = 5'($urandom);
            drive_alu(op, a, b, imm, ui, rd, ctrl);
            exp = alu_ref(op, a, ui ? imm : b);
            tick();
            $display("alu op=%0d a=%h b=%h -> %h", op, a, ui ? imm : b, PIP_alu_result_o);
            checks++;
            if (PIP_alu_result_o !== exp) begin
                failures++; $display("FAIL alu op=%0d: got %h expected %h", op, PIP_alu_result_o, exp);
            end
            checks++;
            if (PIP_rd_o !== rd || {PIP_write_mem_o, PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o} !== ctrl) begin
                failures++; $display("FAIL alu_ctrl: got rd=%0d ctrl=%b expected rd=%0d ctrl=%b", PIP_rd_o,
                    {PIP_write_mem_o, PIP_read_mem_o, PIP_use_mem_o, PIP_write_reg_o}, rd, ctrl);
            end
        end
    endtask

    task automatic test_shift;
        drive_alu(4'd7, 32'd1, 32'd33, 32'd0, 1'b0, 5'd1, 4'b0001);
        tick();
        checks++;
        if (PIP_alu_result_o !== 32'd2) begin
            failures++; $display("FAIL sll_mask: got %h expected 00000002", PIP_alu_result_o);
        end
        drive_alu(4'd8, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd1, 4'b0001);
        tick();
        checks++;
        if (PIP_alu_result_o !== 32'hF800_0000) begin
            failures++; $display("FAIL sra: got %h expected f8000000", PIP_alu_result_o);
        end
        drive_alu(4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1, 4'b0001);
        tick();
        checks++;
        if (PIP_alu_result_o !== 32'd0) begin
            failures++; $display("FAIL unknown_op: got %h expected 0", PIP_alu_result_o);
        end
    endtask

    task automatic test_mul;
        int st; logic [31:0] res, a, b, exp; logic [4:0] rdo; logic wr, bb; logic [2:0] op;
        exec_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, st, res, rdo, wr, bb);
        checks++;
        if (res !== 32'hFFFF_FFFE) begin
            failures++; $display("FAIL mulhu: got %h expected fffffffe", res);
        end
        checks++;
        if (st != MUL_STALL || bb !== 1'b0 || wr !== 1'b1 || rdo !== 5'd9) begin
            failures++; $display("FAIL mul_timing: got stalls=%0d bubble_bad=%b wr=%b rd=%0d expected %0d/0/1/9", st, bb, wr, rdo, MUL_STALL);
        end
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            exp = md_ref(op, a, b);
            exec_md(op, a, b, 5'(i + 1), 1'($urandom), st, res, rdo, wr, bb);
            checks++;
            if (res !== exp || st != MUL_STALL || bb !== 1'b0 || wr !== 1'b1) begin
                failures++; $display("FAIL mul_random op=%0d: got %h stalls=%0d expected %h stalls=%0d", op, res, st, exp, MUL_STALL);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  dop[5] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
        logic [31:0] da[5]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000};
        logic [31:0] db[5]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] dq[5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        int st; logic [31:0] res, a, b, exp; logic [4:0] rdo; logic wr, bb; logic [2:0] op;
        for (int i = 0; i < 5; i++) begin
            exec_md(dop[i], da[i], db[i], 5'd4, 1'b0, st, res, rdo, wr, bb);
            checks++;
            if (res !== dq[i] || st != DIV_STALL || bb !== 1'b0 || wr !== 1'b1) begin
                failures++; $display("FAIL div_directed %0d: got %h stalls=%0d expected %h stalls=%0d", i, res, st, dq[i], DIV_STALL);
            end
        end
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(4, 7)); a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp = md_ref(op, a, b);
            exec_md(op, a, b, 5'(i + 2), 1'($urandom), st, res, rdo, wr, bb);
            checks++;
            if (res !== exp || st != DIV_STALL || bb !== 1'b0) begin
                failures++; $display("FAIL div_random op=%0d a=%h b=%h: got %h stalls=%0d expected %h", op, a, b, res, st, exp);
            end
        end
    endtask

    task automatic test_flush;
        logic late;
        drive_alu(4'd0, 32'd1000, 32'd3, 32'd0, 1'b0, 5'd6, 4'b0001);
        PIP_md_valid_i = 1'b1; PIP_md_op_i = 3'd4;
        repeat (10) tick();
        checks++;
        if (md_busy_o !== 1'b1) begin
            failures++; $display("FAIL flush_pre_busy: got %b expected 1", md_busy_o);
        end
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++; $display("FAIL flush_stall: got %b expected 0", stall_o);
        end
        tick();
        flush_i = 1'b0;
        drive_alu(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        #1;
        $display("flush busy=%b stall=%b wr=%b rd=%0d", md_busy_o, stall_o, PIP_write_reg_o, PIP_rd_o);
        checks++;
        if (md_busy_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL flush_idle: got busy=%b stall=%b expected 0/0", md_busy_o, stall_o);
        end
        checks++;
        if (PIP_write_reg_o !== 1'b0 || PIP_rd_o !== 5'd0) begin
            failures++; $display("FAIL flush_bubble: got wr=%b rd=%0d expected 0/0", PIP_write_reg_o, PIP_rd_o);
        end
        late = 1'b0;
        repeat (40) begin
            tick();
            if (PIP_write_reg_o !== 1'b0 || md_busy_o !== 1'b0) late = 1'b1;
        end
        checks++;
        if (late !== 1'b0) begin
            failures++; $display("FAIL flush_no_result: got late=%b expected 0", late);
        end
        // Flush beats acceptance and also kills a plain ALU instruction.
        drive_alu(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd5, 4'b0001);
        PIP_md_valid_i = 1'b1; PIP_md_op_i = 3'd0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive_alu(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        #1;
        checks++;
        if (md_busy_o !== 1'b0 || PIP_write_reg_o !== 1'b0 || PIP_rd_o !== 5'd0) begin
            failures++; $display("FAIL flush_accept: got busy=%b wr=%b rd=%0d expected 0/0/0", md_busy_o, PIP_write_reg_o, PIP_rd_o);
        end
    endtask

    task automatic test_reset_mid;
        logic late;
        drive_alu(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd3, 4'b0001);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (PIP_alu_result_o !== 32'd0 || PIP_write_reg_o !== 1'b0 || PIP_rd_o !== 5'd0) begin
            failures++; $display("FAIL reset_async_alu: got %h/%b/%0d expected 0", PIP_alu_result_o, PIP_write_reg_o, PIP_rd_o);
        end
        tick();
        reset = 1'b0;
        drive_alu(4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'd8, 4'b0001);
        PIP_md_valid_i = 1'b1; PIP_md_op_i = 3'd0;
        tick();
        checks++;
        if (md_busy_o !== 1'b1) begin
            failures++; $display("FAIL reset_mid_pre_busy: got %b expected 1", md_busy_o);
        end
        #2;
        reset = 1'b1;
        #1;
        $display("reset mid-mul busy=%b stall=%b", md_busy_o, stall_o);
        checks++;
        if (md_busy_o !== 1'b0 || stall_o !== 1'b0 || PIP_write_reg_o !== 1'b0 || PIP_alu_result_o !== 32'd0) begin
            failures++; $display("FAIL reset_mid: got busy=%b stall=%b wr=%b res=%h expected 0", md_busy_o, stall_o, PIP_write_reg_o, PIP_alu_result_o);
        end
        tick();
        reset = 1'b0;
        drive_alu(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        late = 1'b0;
        repeat (6) begin
            tick();
            if (PIP_write_reg_o !== 1'b0 || md_busy_o !== 1'b0) late = 1'b1;
        end
        checks++;
        if (late !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_result: got late=%b expected 0", late);
        end
    endtask

    task automatic test_back_to_back;
        int st; logic [31:0] res; logic [4:0] rdo; logic wr, bb;
        exec_md(3'd0, 32'd2, 32'd7, 5'd1, 1'b0, st, res, rdo, wr, bb);
        checks++;
        if (res !== 32'd14 || rdo !== 5'd1 || wr !== 1'b1 || st != MUL_STALL) begin
            failures++; $display("FAIL b2b_mul: got %0d rd=%0d stalls=%0d expected 14 rd=1 stalls=%0d", res, rdo, st, MUL_STALL);
        end
        exec_md(3'd5, 32'd100, 32'd7, 5'd2, 1'b0, st, res, rdo, wr, bb);
        checks++;
        if (res !== 32'd14 || rdo !== 5'd2 || wr !== 1'b1 || st != DIV_STALL) begin
            failures++; $display("FAIL b2b_divu: got %0d rd=%0d stalls=%0d expected 14 rd=2 stalls=%0d", res, rdo, st, DIV_STALL);
        end
        drive_alu(4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 5'd3, 4'b0001);
        tick();
        $display("b2b add -> %0d rd=%0d", PIP_alu_result_o, PIP_rd_o);
        checks++;
        if (PIP_alu_result_o !== 32'd42 || PIP_rd_o !== 5'd3 || PIP_write_reg_o !== 1'b1) begin
            failures++; $display("FAIL b2b_add: got %0d rd=%0d expected 42 rd=3", PIP_alu_result_o, PIP_rd_o);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        flush_i = 1'b0;
        EX_MEM_operand_i = '0;
        MEM_WB_operand_i = '0;
        drive_alu(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        test_reset();
        test_forwarding();
        test_alu_random();
        test_shift();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
